// File: rtl/log_capture_engine_pkg.sv
// Shared state encodings, mode encodings and the I/Q word-packing helpers
// used by log_capture_engine.
package log_capture_pkg;

  typedef logic [2:0] cap_state_t;

  localparam cap_state_t ST_IDLE      = 3'd0;
  localparam cap_state_t ST_ARMED     = 3'd1;
  localparam cap_state_t ST_CAPTURE   = 3'd2;
  localparam cap_state_t ST_SNAP_WAIT = 3'd3;
  localparam cap_state_t ST_SNAP_DUMP = 3'd4;
  localparam cap_state_t ST_DONE      = 3'd5;

  localparam logic MODE_STREAM = 1'b0;
  localparam logic MODE_SNAP   = 1'b1;

  // Helpers work on a fixed 64-bit container; callers cast down to RAM_WIDTH.
  localparam int PACK_MAX = 64;

  function automatic logic [PACK_MAX-1:0] sext(input logic [PACK_MAX-1:0] raw,
                                               input int nbt);
    logic [PACK_MAX-1:0] mask;
    logic [5:0]          msb;
    mask = (64'd1 << nbt) - 64'd1;
    msb  = 6'(nbt - 1);
    return raw[msb] ? (raw | ~mask) : (raw & mask);
  endfunction

  // I lands in the upper half, Q in the lower half, both sign-extended.
  function automatic logic [PACK_MAX-1:0] pack_word(input logic [PACK_MAX-1:0] i_raw,
                                                    input logic [PACK_MAX-1:0] q_raw,
                                                    input int nbt,
                                                    input int half);
    logic [PACK_MAX-1:0] half_mask;
    half_mask = (64'd1 << half) - 64'd1;
    return (sext(i_raw, nbt) << half) | (sext(q_raw, nbt) & half_mask);
  endfunction

endpackage

// File: rtl/log_capture_engine_sdp_block_ram.sv
// Simple dual-port block RAM: one write port, one read port with a
// registered (read-first) output. Contents are not reset.
module sdp_block_ram #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32768
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         wr_en,
  input  logic [$clog2(RAM_DEPTH)-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]         wr_data,
  input  logic                         rd_en,
  input  logic [$clog2(RAM_DEPTH)-1:0] rd_addr,
  output logic [RAM_WIDTH-1:0]         rd_data
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/log_capture_engine.sv
// Start/stop capture of a selected I/Q stream or periodic tap snapshots into
// an internal RAM. Build option LOG_CIRCULAR_EN makes stream capture wrap.
//
// state      | meaning
// IDLE       | nothing armed since reset
// ARMED      | one cycle after start, config latched
// CAPTURE    | stream mode, writing decimated strobes
// SNAP_WAIT  | snapshot mode, waiting for the next snapshot instant
// SNAP_DUMP  | writing the frozen tap bank, one tap per cycle
// DONE       | capture ended, count held
module log_capture_engine
  import log_capture_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int NBT_SRC     = 12,
  parameter int NUM_TAPS    = 9,
  parameter int NBT_TAPS    = 10,
  parameter int SNAP_PERIOD = 500,
  parameter int RAM_WIDTH   = 32,
  parameter int RAM_DEPTH   = 32768,
  parameter int NBT_DECIM   = 8
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_snap_mode,
  input  logic [$clog2(NUM_SRC)-1:0]    i_src_sel,
  input  logic [NUM_SRC-1:0]            i_src_valid,
  input  logic [NUM_SRC*NBT_SRC-1:0]    i_src_i,
  input  logic [NUM_SRC*NBT_SRC-1:0]    i_src_q,
  input  logic [NBT_DECIM-1:0]          i_decim,
  input  logic [NUM_TAPS*NBT_TAPS-1:0]  i_taps_i,
  input  logic [NUM_TAPS*NBT_TAPS-1:0]  i_taps_q,
  input  logic                          i_rd_en,
  input  logic [$clog2(RAM_DEPTH)-1:0]  i_rd_addr,
  output logic [RAM_WIDTH-1:0]          o_rd_data,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(RAM_DEPTH):0]    o_wr_count
`ifdef LOG_CIRCULAR_EN
  ,
  output logic [$clog2(RAM_DEPTH)-1:0]  o_wrap_ptr
`endif
);

  localparam int AW   = $clog2(RAM_DEPTH);
  localparam int CW   = AW + 1;
  localparam int SW   = $clog2(NUM_SRC);
  localparam int TW   = $clog2(NUM_TAPS);
  localparam int DW   = $clog2(SNAP_PERIOD);
  localparam int HALF = RAM_WIDTH / 2;
  // SNAP_WAIT lasts SNAP_PERIOD-1 cycles: count DLY_LOAD down to 0.
  localparam logic [DW-1:0] DLY_LOAD = DW'(SNAP_PERIOD - 2);

  cap_state_t                  state;
  logic                        mode_q;
  logic [SW-1:0]               src_sel_q;
  logic [NBT_DECIM-1:0]        decim_q;
  logic [NBT_DECIM-1:0]        dec_cnt;
  logic [DW-1:0]               dly_cnt;
  logic [TW-1:0]               tap_idx;
  logic [AW-1:0]               wr_addr;
  logic [CW-1:0]               wr_count;
  logic                        stop_pend;
  logic [NUM_TAPS*NBT_TAPS-1:0] taps_i_q;
  logic [NUM_TAPS*NBT_TAPS-1:0] taps_q_q;
`ifdef LOG_CIRCULAR_EN
  logic                        wrapped;
`endif

  logic                        src_vld_sel;
  logic [NBT_SRC-1:0]          src_i_sel;
  logic [NBT_SRC-1:0]          src_q_sel;
  logic [NBT_TAPS-1:0]         tap_i_sel;
  logic [NBT_TAPS-1:0]         tap_q_sel;
  logic [PACK_MAX-1:0]         raw_src_i;
  logic [PACK_MAX-1:0]         raw_src_q;
  logic [PACK_MAX-1:0]         raw_tap_i;
  logic [PACK_MAX-1:0]         raw_tap_q;
  logic                        stream_wr;
  logic                        dump_wr;
  logic                        wr_en;
  logic [RAM_WIDTH-1:0]        wr_data;
  logic                        at_last;
  logic                        space_ok;

  always_comb begin
    src_vld_sel = 1'b0;
    src_i_sel   = '0;
    src_q_sel   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel_q == SW'(k)) begin
        src_vld_sel = i_src_valid[k];
        src_i_sel   = i_src_i[k*NBT_SRC +: NBT_SRC];
        src_q_sel   = i_src_q[k*NBT_SRC +: NBT_SRC];
      end
    end
  end

  always_comb begin
    tap_i_sel = '0;
    tap_q_sel = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (tap_idx == TW'(k)) begin
        tap_i_sel = taps_i_q[k*NBT_TAPS +: NBT_TAPS];
        tap_q_sel = taps_q_q[k*NBT_TAPS +: NBT_TAPS];
      end
    end
  end

  always_comb begin
    raw_src_i = '0;
    raw_src_q = '0;
    raw_tap_i = '0;
    raw_tap_q = '0;
    raw_src_i[NBT_SRC-1:0]  = src_i_sel;
    raw_src_q[NBT_SRC-1:0]  = src_q_sel;
    raw_tap_i[NBT_TAPS-1:0] = tap_i_sel;
    raw_tap_q[NBT_TAPS-1:0] = tap_q_sel;
  end

  assign stream_wr = (state == ST_CAPTURE) && src_vld_sel && (dec_cnt == '0);
  assign dump_wr   = (state == ST_SNAP_DUMP);
  assign wr_en     = stream_wr || dump_wr;
  assign wr_data   = dump_wr ? RAM_WIDTH'(pack_word(raw_tap_i, raw_tap_q, NBT_TAPS, HALF))
                             : RAM_WIDTH'(pack_word(raw_src_i, raw_src_q, NBT_SRC, HALF));
  assign at_last   = (wr_addr == AW'(RAM_DEPTH - 1));
  assign space_ok  = (CW'(RAM_DEPTH) - wr_count) >= CW'(NUM_TAPS);

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_STREAM;
      src_sel_q <= '0;
      decim_q   <= '0;
      dec_cnt   <= '0;
      dly_cnt   <= '0;
      tap_idx   <= '0;
      wr_addr   <= '0;
      wr_count  <= '0;
      stop_pend <= 1'b0;
      taps_i_q  <= '0;
      taps_q_q  <= '0;
`ifdef LOG_CIRCULAR_EN
      wrapped   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state     <= ST_ARMED;
            mode_q    <= i_snap_mode;
            src_sel_q <= i_src_sel;
            decim_q   <= i_decim;
            dec_cnt   <= '0;
            dly_cnt   <= DLY_LOAD;
            tap_idx   <= '0;
            wr_addr   <= '0;
            wr_count  <= '0;
            stop_pend <= 1'b0;
`ifdef LOG_CIRCULAR_EN
            wrapped   <= 1'b0;
`endif
          end
        end
        ST_ARMED: begin
          state <= (mode_q == MODE_SNAP) ? ST_SNAP_WAIT : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (src_vld_sel) dec_cnt <= (dec_cnt == '0) ? decim_q : dec_cnt - NBT_DECIM'(1);
          if (stream_wr) begin
            wr_addr <= wr_addr + AW'(1);
`ifdef LOG_CIRCULAR_EN
            if (wr_count != CW'(RAM_DEPTH)) wr_count <= wr_count + CW'(1);
            if (at_last) wrapped <= 1'b1;
`else
            wr_count <= wr_count + CW'(1);
`endif
          end
`ifdef LOG_CIRCULAR_EN
          if (i_stop) state <= ST_DONE;
`else
          if (i_stop || (stream_wr && at_last)) state <= ST_DONE;
`endif
        end
        ST_SNAP_WAIT: begin
          if (i_stop) begin
            state <= ST_DONE;
          end else if (dly_cnt == '0) begin
            if (space_ok) begin
              taps_i_q <= i_taps_i;
              taps_q_q <= i_taps_q;
              tap_idx  <= '0;
              state    <= ST_SNAP_DUMP;
            end else begin
              state <= ST_DONE;
            end
          end else begin
            dly_cnt <= dly_cnt - DW'(1);
          end
        end
        ST_SNAP_DUMP: begin
          wr_addr  <= wr_addr + AW'(1);
          wr_count <= wr_count + CW'(1);
          if (i_stop) stop_pend <= 1'b1;
          if (tap_idx == TW'(NUM_TAPS - 1)) begin
            if (stop_pend || i_stop || at_last) begin
              state <= ST_DONE;
            end else begin
              dly_cnt <= DLY_LOAD;
              state   <= ST_SNAP_WAIT;
            end
          end else begin
            tap_idx <= tap_idx + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy     = (state == ST_ARMED) || (state == ST_CAPTURE) ||
                      (state == ST_SNAP_WAIT) || (state == ST_SNAP_DUMP);
  assign o_done     = (state == ST_DONE);
  assign o_wr_count = wr_count;
`ifdef LOG_CIRCULAR_EN
  // Once wrapped, the next write address holds the oldest sample.
  assign o_wrap_ptr = wrapped ? wr_addr : '0;
`endif

  sdp_block_ram #(
    .RAM_WIDTH (RAM_WIDTH),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_reset (i_reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (i_rd_en),
    .rd_addr (i_rd_addr),
    .rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_log_capture_engine.sv
// Scoreboard bench for log_capture_engine with a reduced RAM depth and
// snapshot period so full and snapshot runs stay short.
module tb_log_capture_engine;

  localparam int NUM_SRC     = 2;
  localparam int NBT_SRC     = 12;
  localparam int NUM_TAPS    = 9;
  localparam int NBT_TAPS    = 10;
  localparam int SNAP_PERIOD = 16;
  localparam int RAM_WIDTH   = 32;
  localparam int RAM_DEPTH   = 1024;
  localparam int NBT_DECIM   = 8;
  localparam int AW          = 10;

  logic                         clk = 1'b0;
  logic                         i_reset = 1'b0;
  logic                         i_start = 1'b0;
  logic                         i_stop = 1'b0;
  logic                         i_snap_mode = 1'b0;
  logic [0:0]                   i_src_sel = '0;
  logic [NUM_SRC-1:0]           i_src_valid = '0;
  logic [NUM_SRC*NBT_SRC-1:0]   i_src_i = '0;
  logic [NUM_SRC*NBT_SRC-1:0]   i_src_q = '0;
  logic [NBT_DECIM-1:0]         i_decim = '0;
  logic [NUM_TAPS*NBT_TAPS-1:0] i_taps_i = '0;
  logic [NUM_TAPS*NBT_TAPS-1:0] i_taps_q = '0;
  logic                         i_rd_en = 1'b0;
  logic [AW-1:0]                i_rd_addr = '0;
  logic [RAM_WIDTH-1:0]         o_rd_data;
  logic                         o_busy;
  logic                         o_done;
  logic [AW:0]                  o_wr_count;
`ifdef LOG_CIRCULAR_EN
  logic [AW-1:0]                o_wrap_ptr;
`endif

  log_capture_engine #(
    .NUM_SRC(NUM_SRC), .NBT_SRC(NBT_SRC), .NUM_TAPS(NUM_TAPS), .NBT_TAPS(NBT_TAPS),
    .SNAP_PERIOD(SNAP_PERIOD), .RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH),
    .NBT_DECIM(NBT_DECIM)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_snap_mode(i_snap_mode), .i_src_sel(i_src_sel), .i_src_valid(i_src_valid),
    .i_src_i(i_src_i), .i_src_q(i_src_q), .i_decim(i_decim),
    .i_taps_i(i_taps_i), .i_taps_q(i_taps_q), .i_rd_en(i_rd_en),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_busy(o_busy),
    .o_done(o_done), .o_wr_count(o_wr_count)
`ifdef LOG_CIRCULAR_EN
    , .o_wrap_ptr(o_wrap_ptr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hist [0:1399];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stream_word(input logic [11:0] iv, input logic [11:0] qv);
    return {{4{iv[11]}}, iv, {4{qv[11]}}, qv};
  endfunction

  function automatic logic [31:0] tap_word(input logic [9:0] iv, input logic [9:0] qv);
    return {{6{iv[9]}}, iv, {6{qv[9]}}, qv};
  endfunction

  function automatic logic [9:0] tap_i_f(input int c, input int t);
    return 10'((c * 37 + t * 101) & 1023);
  endfunction

  function automatic logic [9:0] tap_q_f(input int c, input int t);
    return 10'((c * 53 + t * 29 + 512) & 1023);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_cap(input logic mode, input logic sel, input logic [7:0] dec);
    i_start = 1'b1; i_snap_mode = mode; i_src_sel = sel; i_decim = dec;
    tick();
    i_start = 1'b0;
  endtask

  task automatic stop_cap();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask

  task automatic read_word(input int addr, output logic [31:0] d);
    i_rd_en = 1'b1; i_rd_addr = AW'(addr);
    tick();
    i_rd_en = 1'b0;
    d = o_rd_data;
  endtask

  task automatic drive_taps(input int c);
    for (int t = 0; t < NUM_TAPS; t++) begin
      i_taps_i[t*NBT_TAPS +: NBT_TAPS] = tap_i_f(c, t);
      i_taps_q[t*NBT_TAPS +: NBT_TAPS] = tap_q_f(c, t);
    end
  endtask

  task automatic drain(input int n);
    logic [31:0] d;
    for (int a = 0; a < n; a++) begin
      read_word(a, d);
      if (exp_q.size() == 0) chk($sformatf("sb_empty[%0d]", a), 64'd1, 64'd0);
      else chk($sformatf("rd[%0d]", a), 64'(d), 64'(exp_q.pop_front()));
    end
    chk("sb_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, w5, old0;
    logic [11:0] si, sq;
    int c, k;

    repeat (3) tick();
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_count", 64'(o_wr_count), 64'd0);
    chk("rst_rd", 64'(o_rd_data), 64'd0);
    i_reset = 1'b1;
    tick();

    // Stream, source 1, every strobe written
    start_cap(1'b0, 1'b1, 8'd0);
    tick();
    chk("t1_busy", 64'(o_busy), 64'd1);
    w5 = '0;
    for (int s = 0; s < 100; s++) begin
      si = 12'($urandom); sq = 12'($urandom);
      i_src_i[23:12] = si; i_src_q[23:12] = sq;
      i_src_i[11:0] = 12'($urandom); i_src_q[11:0] = 12'($urandom);
      i_src_valid = {1'b1, 1'($urandom)};
      exp_q.push_back(stream_word(si, sq));
      if (s == 5) w5 = stream_word(si, sq);
      tick();
    end
    i_src_valid = '0;
    stop_cap();
    chk("t1_done", 64'(o_done), 64'd1);
    chk("t1_busy_off", 64'(o_busy), 64'd0);
    chk("t1_count", 64'(o_wr_count), 64'd100);
    read_word(5, d);
    chk("t1_addr5", 64'(d), 64'(w5));
    drain(100);

    // Stream, source 0, decimate by 4, irregular strobes
    start_cap(1'b0, 1'b0, 8'd3);
    tick();
    for (int s = 0; s < 40; s++) begin
      si = 12'($urandom); sq = 12'($urandom);
      i_src_i[11:0] = si; i_src_q[11:0] = sq;
      i_src_valid = 2'b01;
      if (s % 4 == 0) exp_q.push_back(stream_word(si, sq));
      tick();
      if (s % 2 == 1) begin
        i_src_valid = 2'b10;
        tick();
      end
    end
    i_src_valid = '0;
    stop_cap();
    chk("t2_count", 64'(o_wr_count), 64'd10);
    drain(10);

    // Sign extension; last write coincides with stop
    start_cap(1'b0, 1'b0, 8'd0);
    tick();
    i_src_valid = 2'b01;
    i_src_i[11:0] = 12'hFFF; i_src_q[11:0] = 12'hFFF; tick();
    i_src_i[11:0] = 12'h000; i_src_q[11:0] = 12'h800; tick();
    i_src_i[11:0] = 12'h800; i_src_q[11:0] = 12'h000; tick();
    i_src_i[11:0] = 12'h7FF; i_src_q[11:0] = 12'h7FF; i_stop = 1'b1; tick();
    i_stop = 1'b0; i_src_valid = '0;
    chk("t3_done", 64'(o_done), 64'd1);
    chk("t3_count", 64'(o_wr_count), 64'd4);
    read_word(0, d); chk("t3_neg1", 64'(d), 64'h0000_0000_FFFF_FFFF);
    read_word(1, d); chk("t3_qmin", 64'(d), 64'h0000_0000_0000_F800);
    read_word(2, d); chk("t3_imin", 64'(d), 64'h0000_0000_F800_0000);
    read_word(3, d); chk("t3_max", 64'(d), 64'h0000_0000_07FF_07FF);

    // Snapshot run to completion: latch at cycle 15 + 24n after ARMED
    for (int n = 0; n < 113; n++)
      for (int t = 0; t < NUM_TAPS; t++)
        exp_q.push_back(tap_word(tap_i_f(15 + 24 * n, t), tap_q_f(15 + 24 * n, t)));
    start_cap(1'b1, 1'b0, 8'd0);
    c = 0;
    while (c < 6000 && !o_done) begin
      drive_taps(c);
      tick();
      c++;
    end
    chk("snap_done", 64'(o_done), 64'd1);
    chk("snap_done_cycle", 64'(c), 64'd2728);
    chk("snap_count", 64'(o_wr_count), 64'd1017);
    drain(1017);

    // Stop during SNAP_DUMP completes the snapshot
    for (int t = 0; t < NUM_TAPS; t++) exp_q.push_back(tap_word(tap_i_f(15, t), tap_q_f(15, t)));
    start_cap(1'b1, 1'b0, 8'd0);
    c = 0;
    while (c < 200 && !o_done) begin
      drive_taps(c);
      i_stop = (c == 18);
      tick();
      c++;
    end
    i_stop = 1'b0;
    chk("dstop_cycle", 64'(c), 64'd25);
    chk("dstop_count", 64'(o_wr_count), 64'd9);
    drain(9);

    // Stream until full (or wrapped), start mid-capture ignored
    start_cap(1'b0, 1'b0, 8'd0);
    tick();
    k = 0;
`ifdef LOG_CIRCULAR_EN
    while (k < 1300) begin
`else
    while (k < 1100 && !o_done) begin
`endif
      si = 12'($urandom); sq = 12'($urandom);
      i_src_i[11:0] = si; i_src_q[11:0] = sq; i_src_valid = 2'b01;
      hist[k] = stream_word(si, sq);
      i_start = (k == 500);
      if (k == 510) begin
        chk("full_start_ign_cnt", 64'(o_wr_count), 64'd510);
        chk("full_start_ign_busy", 64'(o_busy), 64'd1);
      end
      tick();
      k++;
    end
    i_start = 1'b0; i_src_valid = '0;
`ifdef LOG_CIRCULAR_EN
    stop_cap();
    chk("circ_count", 64'(o_wr_count), 64'd1024);
    chk("circ_wrap_ptr", 64'(o_wrap_ptr), 64'd276);
    read_word(276, d); chk("circ_oldest", 64'(d), 64'(hist[276]));
    old0 = hist[1024];
`else
    chk("full_writes", 64'(k), 64'd1024);
    read_word(1023, d); chk("full_last", 64'(d), 64'(hist[1023]));
    read_word(512, d); chk("full_mid", 64'(d), 64'(hist[512]));
    old0 = hist[0];
`endif
    chk("full_done", 64'(o_done), 64'd1);
    chk("full_count", 64'(o_wr_count), 64'd1024);

    // Restart from DONE; stop in ARMED ignored; same-cycle read returns old data
    start_cap(1'b0, 1'b0, 8'd0);
    chk("rs_count0", 64'(o_wr_count), 64'd0);
    chk("rs_done0", 64'(o_done), 64'd0);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("rs_stop_armed", 64'(o_busy), 64'd1);
    i_src_i[11:0] = 12'h123; i_src_q[11:0] = 12'h456; i_src_valid = 2'b01;
    i_rd_en = 1'b1; i_rd_addr = '0;
    tick();
    i_src_valid = '0; i_rd_en = 1'b0;
    chk("rs_rd_old", 64'(o_rd_data), 64'(old0));
    read_word(0, d); chk("rs_rd_new", 64'(d), 64'h0000_0000_0123_0456);
    chk("rs_count1", 64'(o_wr_count), 64'd1);
    stop_cap();

    // Start and stop together in DONE: start wins; then reset mid-capture
    i_start = 1'b1; i_stop = 1'b1; i_snap_mode = 1'b0; i_src_sel = 1'b0; i_decim = 8'd0;
    tick();
    i_start = 1'b0; i_stop = 1'b0;
    chk("ss_start_wins", 64'(o_busy), 64'd1);
    tick();
    for (int s = 0; s < 1000; s++) begin
      si = 12'($urandom); sq = 12'($urandom);
      i_src_i[11:0] = si; i_src_q[11:0] = sq; i_src_valid = 2'b01;
      hist[s] = stream_word(si, sq);
      tick();
    end
    chk("rm_count1000", 64'(o_wr_count), 64'd1000);
    read_word(0, d);
    chk("rm_rd_live", 64'(d), 64'(hist[0]));
    i_reset = 1'b0;
    #1;
    chk("rm_busy", 64'(o_busy), 64'd0);
    chk("rm_done", 64'(o_done), 64'd0);
    chk("rm_count", 64'(o_wr_count), 64'd0);
    chk("rm_rd", 64'(o_rd_data), 64'd0);
    tick();
    i_reset = 1'b1; i_src_valid = '0;
    tick();
    chk("rm_idle", 64'(o_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
